// File: rtl/ps_bigreg_bank_if.sv
// -----------------------------------------------------------------------------
// ps_bigreg_bank_if
// Bundles the PS write strobe, the per-channel committed-value handshake and
// the error/status outputs of ps_bigreg_bank.
//   slave  : the bank (consumes wr_*, out_ready; drives everything else)
//   master : the register decode / RTL consumer side
// Signals:
//   wr_en, wr_id, wr_data   PS write strobe, index and data
//   out_data, out_valid     committed wide value per channel, pending flag
//   out_ready               consumer accept per channel
//   ch_armed                all words of a channel are fresh
//   hit                     last write landed in this bank
//   err_pulse/code/ch       error strobe, code (1 INCOMPLETE, 2 BUSY), channel
// Optional (PS_BIGREG_READBACK_EN): rd_en, rd_id, rd_data, rd_valid.
// -----------------------------------------------------------------------------
interface ps_bigreg_bank_if #(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 16,
   parameter int NUM_CH     = 3,
   parameter int ID_WIDTH   = 8
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                                       wr_en;
   logic [ID_WIDTH-1:0]                        wr_id;
   logic [DATA_WIDTH-1:0]                      wr_data;
   logic [NUM_CH-1:0][WORDS*DATA_WIDTH-1:0]    out_data;
   logic [NUM_CH-1:0]                          out_valid;
   logic [NUM_CH-1:0]                          out_ready;
   logic [NUM_CH-1:0]                          ch_armed;
   logic                                       hit;
   logic                                       err_pulse;
   logic [1:0]                                 err_code;
   logic [CH_W-1:0]                            err_ch;
`ifdef PS_BIGREG_READBACK_EN
   logic                                       rd_en;
   logic [ID_WIDTH-1:0]                        rd_id;
   logic [DATA_WIDTH-1:0]                      rd_data;
   logic                                       rd_valid;

   modport slave (
      input  wr_en, wr_id, wr_data, out_ready, rd_en, rd_id,
      output out_data, out_valid, ch_armed, hit, err_pulse, err_code, err_ch,
             rd_data, rd_valid
   );
   modport master (
      output wr_en, wr_id, wr_data, out_ready, rd_en, rd_id,
      input  out_data, out_valid, ch_armed, hit, err_pulse, err_code, err_ch,
             rd_data, rd_valid
   );
`else
   modport slave (
      input  wr_en, wr_id, wr_data, out_ready,
      output out_data, out_valid, ch_armed, hit, err_pulse, err_code, err_ch
   );
   modport master (
      output wr_en, wr_id, wr_data, out_ready,
      input  out_data, out_valid, ch_armed, hit, err_pulse, err_code, err_ch
   );
`endif
endinterface

// File: rtl/ps_bigreg_bank.sv
// -----------------------------------------------------------------------------
// ps_bigreg_bank
// Collects PS-written multi-word registers. Each channel stages word writes
// with a fresh bit per word and, when its valid index is written while all
// words are fresh, atomically commits the assembled value to out_data and
// raises out_valid until the consumer accepts it.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset (clears all state, including staging)
//   bus  ps_bigreg_bank_if.slave (write strobe, per-channel handshake, errors)
// Index map: channel c word k at BASE_ID + c*(WORDS+1) + k, valid index at
// BASE_ID + c*(WORDS+1) + WORDS.
// Optional feature macro: PS_BIGREG_READBACK_EN (adds rd_* readback port).
// -----------------------------------------------------------------------------
module ps_bigreg_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int WORDS      = 16,
   parameter int NUM_CH     = 3,
   parameter int BASE_ID    = 1,
   parameter int ID_WIDTH   = 8
) (
   input logic             clk,
   input logic             rst,
   ps_bigreg_bank_if.slave bus
);
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int REG_W = WORDS * DATA_WIDTH;
   localparam int SPAN  = WORDS + 1;

   localparam logic [1:0] ERR_INCOMPLETE = 2'd1;
   localparam logic [1:0] ERR_BUSY       = 2'd2;

   if (longint'(BASE_ID) + longint'(NUM_CH) * SPAN > (longint'(1) << ID_WIDTH)) begin : g_map_check
      $error("ps_bigreg_bank: index map does not fit in ID_WIDTH");
   end

   typedef enum logic {COLLECT = 1'b0, ARMED = 1'b1} ch_state_e;

   ch_state_e [NUM_CH-1:0]          state_q, state_d;
   logic [NUM_CH-1:0][WORDS-1:0]    fresh_q, fresh_d;
   logic [NUM_CH-1:0][REG_W-1:0]    stg_q, stg_d;
   logic [NUM_CH-1:0][REG_W-1:0]    out_data_q, out_data_d;
   logic [NUM_CH-1:0]               out_valid_q, out_valid_d;
   logic                            hit_q, hit_d;
   logic                            err_pulse_q, err_pulse_d;
   logic [1:0]                      err_code_q, err_code_d;
   logic [CH_W-1:0]                 err_ch_q, err_ch_d;

   logic [NUM_CH-1:0][WORDS-1:0]    wsel;
   logic [NUM_CH-1:0]               vsel;
   logic [NUM_CH-1:0]               commit;

   // Address decode: one-hot word selects and valid-index selects.
   always_comb begin
      wsel = '0;
      vsel = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < WORDS; k++) begin
            if (bus.wr_en && bus.wr_id == ID_WIDTH'(BASE_ID + c*SPAN + k))
               wsel[c][k] = 1'b1;
         end
         if (bus.wr_en && bus.wr_id == ID_WIDTH'(BASE_ID + c*SPAN + WORDS))
            vsel[c] = 1'b1;
      end
   end

   assign hit_d = (|wsel) | (|vsel);

   // Staging, commit, handshake and error generation.
   always_comb begin
      logic busy;
      busy        = 1'b0;
      fresh_d     = fresh_q;
      stg_d       = stg_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      commit      = '0;
      err_pulse_d = 1'b0;
      err_code_d  = err_code_q;
      err_ch_d    = err_ch_q;
      for (int c = 0; c < NUM_CH; c++) begin
         // A pending value the consumer is not taking this cycle blocks commit.
         busy = out_valid_q[c] & ~bus.out_ready[c];
         for (int k = 0; k < WORDS; k++) begin
            if (wsel[c][k]) begin
               stg_d[c][k*DATA_WIDTH +: DATA_WIDTH] = bus.wr_data;
               fresh_d[c][k] = 1'b1;
            end
         end
         if (vsel[c]) begin
            if (state_q[c] != ARMED) begin
               err_pulse_d = 1'b1;
               err_code_d  = ERR_INCOMPLETE;
               err_ch_d    = CH_W'(c);
            end else if (busy) begin
               err_pulse_d = 1'b1;
               err_code_d  = ERR_BUSY;
               err_ch_d    = CH_W'(c);
            end else begin
               commit[c] = 1'b1;
            end
         end
         // Commit wins over a simultaneous accept so the new value stays valid.
         if (commit[c]) begin
            out_data_d[c]  = stg_q[c];
            out_valid_d[c] = 1'b1;
            fresh_d[c]     = '0;
         end else if (out_valid_q[c] && bus.out_ready[c]) begin
            out_valid_d[c] = 1'b0;
         end
      end
   end

   // Per-channel FSM next state.
   always_comb begin
      state_d = state_q;
      for (int c = 0; c < NUM_CH; c++) begin
         case (state_q[c])
            COLLECT: if (&fresh_d[c]) state_d[c] = ARMED;
            ARMED:   if (commit[c])   state_d[c] = COLLECT;
            default: state_d[c] = COLLECT;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int c = 0; c < NUM_CH; c++) state_q[c] <= COLLECT;
         fresh_q     <= '0;
         stg_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= '0;
         hit_q       <= 1'b0;
         err_pulse_q <= 1'b0;
         err_code_q  <= '0;
         err_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         fresh_q     <= fresh_d;
         stg_q       <= stg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         hit_q       <= hit_d;
         err_pulse_q <= err_pulse_d;
         err_code_q  <= err_code_d;
         err_ch_q    <= err_ch_d;
      end
   end

   always_comb begin
      bus.ch_armed = '0;
      for (int c = 0; c < NUM_CH; c++) bus.ch_armed[c] = (state_q[c] == ARMED);
   end

   assign bus.out_data  = out_data_q;
   assign bus.out_valid = out_valid_q;
   assign bus.hit       = hit_q;
   assign bus.err_pulse = err_pulse_q;
   assign bus.err_code  = err_code_q;
   assign bus.err_ch    = err_ch_q;

`ifdef PS_BIGREG_READBACK_EN
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                  rd_valid_q;

   // Data index -> staging word, valid index -> fresh mask, else zero.
   always_comb begin
      rd_data_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         for (int k = 0; k < WORDS; k++) begin
            if (bus.rd_id == ID_WIDTH'(BASE_ID + c*SPAN + k))
               rd_data_d = stg_q[c][k*DATA_WIDTH +: DATA_WIDTH];
         end
         if (bus.rd_id == ID_WIDTH'(BASE_ID + c*SPAN + WORDS)) begin
            for (int b = 0; b < WORDS && b < DATA_WIDTH; b++)
               rd_data_d[b] = fresh_q[c][b];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) rd_data_q <= rd_data_d;
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
`endif

endmodule
